// File: rtl/adder.sv
// adder: registered two's-complement adder with overflow/carry flags and optional saturation
//
// Parameters:
//   WIDTH     operand/result width in bits (a, b, c are signed)
//   SATURATE  0: c wraps modulo 2^WIDTH; 1: c clamps to signed max/min on overflow
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears c, out_valid, overflow, carry
//   in_valid   a/b carry a valid operand pair this cycle
//   a, b       signed operands
//   c          registered signed sum, one cycle after the accepted pair
//   out_valid  c/flags belong to the pair accepted in the previous cycle
//   overflow   signed overflow of the registered result (true even when clamped)
//   carry      unsigned carry-out of bit WIDTH-1 of the registered result
module adder #(
   parameter int WIDTH    = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] c,
   output logic                    out_valid,
   output logic                    overflow,
   output logic                    carry
);
   logic [WIDTH:0]   full;
   logic             ovf;
   logic [WIDTH-1:0] res;
   // Zero-extended add exposes the unsigned carry in the top bit; the signed
   // overflow test only needs the operand and result sign bits.
   always_comb begin
      full = {1'b0, a} + {1'b0, b};
      ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      res  = (SATURATE && ovf) ? (a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                               : full[WIDTH-1:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c         <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         carry     <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            c        <= res;
            overflow <= ovf;
            carry    <= full[WIDTH];
         end
      end
   end
endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench driving a wrapping and a saturating adder in parallel
module tb_adder;
   typedef struct {
      logic [31:0] c;
      logic        ovf;
      logic        car;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [31:0] a = '0;
   logic signed [31:0] b = '0;
   logic signed [31:0] c0, c1;
   logic               v0, v1, o0, o1, k0, k1;
   exp_t               q0[$];
   exp_t               q1[$];
   int                 n_cmp = 0;
   int                 n_bad = 0;

   adder #(.WIDTH(32), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .c(c0), .out_valid(v0), .overflow(o0), .carry(k0)
   );
   adder #(.WIDTH(32), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .c(c1), .out_valid(v1), .overflow(o1), .carry(k1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] cw,
                       input logic ov, input logic cr, input logic [31:0] cs);
      @(posedge clk);
      #1;
      q0.push_back('{cw, ov, cr});
      q1.push_back('{cs, ov, cr});
      a        = x;
      b        = y;
      in_valid = 1'b1;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 32'h5A5A_5A5A;
      b        = 32'h1234_5678;
   endtask

   // Monitor: pops one expected record per presented result for each instance.
   always @(negedge clk) begin
      exp_t e;
      if (v0 === 1'b1) begin
         if (q0.size() == 0) chk("wrap_unexpected_out", 32'd1, 32'd0);
         else begin
            e = q0.pop_front();
            chk("wrap_c", c0, e.c);
            chk("wrap_ovf", {31'd0, o0}, {31'd0, e.ovf});
            chk("wrap_carry", {31'd0, k0}, {31'd0, e.car});
         end
      end
      if (v1 === 1'b1) begin
         if (q1.size() == 0) chk("sat_unexpected_out", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            chk("sat_c", c1, e.c);
            chk("sat_ovf", {31'd0, o1}, {31'd0, e.ovf});
            chk("sat_carry", {31'd0, k1}, {31'd0, e.car});
         end
      end
   end

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_c", c0, 32'd0);
      chk("rst_valid", {31'd0, v0}, 32'd0);
      chk("rst_flags", {30'd0, o0, k0}, 32'd0);
      chk("rst_sat_c", c1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 32'd7);
      send(-32'sd5, 32'd2, -32'sd3, 1'b0, 1'b0, -32'sd3);
      send(-32'sd1, 32'd1, 32'd0, 1'b0, 1'b1, 32'd0);
      send(32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0, 32'h7FFF_FFFF);
      send(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 32'h8000_0000);
      send(32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 32'd2);
      send(32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 32'd4);
      send(32'd10, -32'sd10, 32'd0, 1'b0, 1'b1, 32'd0);
      idle();
      @(negedge clk);
      @(negedge clk);
      chk("gap_valid", {30'd0, v0, v1}, 32'd0);
      chk("gap_c_hold", c0, 32'd0);
      chk("gap_carry_hold", {30'd0, k0, k1}, 32'b11);
      send(32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 32'd123);
      idle();
      @(negedge clk);
      #2;
      chk("pre_rst_c", c0, 32'd123);
      rst = 1'b1;
      #1;
      chk("async_rst_c", c0, 32'd0);
      chk("async_rst_sat_c", c1, 32'd0);
      chk("async_rst_valid", {30'd0, v0, v1}, 32'd0);
      chk("async_rst_flags", {28'd0, o0, k0, o1, k1}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("wrap_queue_drained", q0.size(), 32'd0);
      chk("sat_queue_drained", q1.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
